// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
//   Sequencing stage in front of a single-port synchronous RAM (registered q,
//   1-cycle read latency, read-old-data on write). Turns the RAM into a
//   streaming FIFO with valid/ready handshakes on both sides. Reads take
//   priority over writes on the shared address port. Words read from the RAM
//   land in a registered output stage.
//
// Ports
//   clk, rst_n        clock shared with the RAM, async active-low reset
//   in_valid/in_ready upstream handshake (in_ready is combinational and
//                     depends on out_ready)
//   in_data           upstream word
//   out_valid/out_ready/out_data  downstream handshake, registered data
//   level             words held: RAM + in-flight read + output register
//   ram_we/ram_addr/ram_d  RAM control (combinational), ram_d = in_data
//   ram_q             RAM read data, meaningful only the cycle after a read

module ram_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam logic [ADDR_WIDTH:0]   DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   mem_cnt_q, mem_cnt_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;

  logic rd_issue;
  logic wr_en;

  // A read is issued only when the output slot will be free by the time the
  // data returns; rd_pend blocks back-to-back reads so at most one word is in
  // flight. Gating with rst_n keeps the RAM port quiet while in reset.
  assign rd_issue = rst_n && (mem_cnt_q != '0) && !rd_pend_q
                    && (!out_valid_q || out_ready);
  assign in_ready = rst_n && (mem_cnt_q != DEPTH) && !rd_issue;
  assign wr_en    = in_valid && in_ready;

  assign ram_we   = wr_en;
  assign ram_addr = rd_issue ? rd_ptr_q : wr_ptr_q;
  assign ram_d    = in_data;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign level     = level_q;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred; blocking '=' is used here.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_cnt_d   = mem_cnt_q;
    rd_pend_d   = rd_issue;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (wr_en) begin
      wr_ptr_d  = wr_ptr_q + PTR_ONE;
      mem_cnt_d = mem_cnt_d + CNT_ONE;
    end
    if (rd_issue) begin
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
      mem_cnt_d = mem_cnt_d - CNT_ONE;
    end

    // The read was only issued if the slot is empty or being popped now, so
    // loading here never overwrites an unconsumed word. ram_q is ignored in
    // every other cycle, including the stale data seen during writes.
    if (rd_pend_q) begin
      out_data_d  = ram_q;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    level_d = mem_cnt_d
            + {{ADDR_WIDTH{1'b0}}, rd_pend_d}
            + {{ADDR_WIDTH{1'b0}}, out_valid_d};
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples the
  // pre-edge values. The RAM array itself is never cleared; the pointers and
  // count alone decide which entries are valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      rd_pend_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      level_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      rd_pend_q   <= rd_pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      level_q     <= level_d;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Testbench for ram_fifo_ctrl with a behavioural 128x32 single-port RAM
// (registered q, read-old-data on write). Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.

module tb_ram_fifo_ctrl;

  localparam int DW = 32;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW:0]   level;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_d;
  logic [DW-1:0] ram_q = '0;

  logic [DW-1:0] mem [2**AW];

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] exp_q [$];
  int n_pop = 0;

  ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_d     (ram_d),
    .ram_q     (ram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_d;
    ram_q <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: pop before push so a word can never match itself.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("sb_order", 64'(out_data), 64'(exp_q.pop_front()));
        n_pop++;
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int target;
    int n_acc;
    int n_sent;
    int start;

    // ---------------- reset and idle ----------------
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    to_neg();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_ram_we", 64'(ram_we), 64'd0);
    check("rst_ram_addr", 64'(ram_addr), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("idle_in_ready", 64'(in_ready), 64'd1);
    check("idle_ram_we", 64'(ram_we), 64'd0);
    to_pos();
    check("idle_level", 64'(level), 64'd0);
    check("idle_out_valid", 64'(out_valid), 64'd0);

    // ---------------- single word latency ----------------
    in_valid  = 1'b1;
    in_data   = 32'hA5A5_0001;
    out_ready = 1'b1;
    to_neg();
    check("t0_ram_we", 64'(ram_we), 64'd1);
    check("t0_ram_addr", 64'(ram_addr), 64'd0);
    to_pos();
    in_valid = 1'b0;
    to_neg();
    check("t1_ram_we", 64'(ram_we), 64'd0);
    check("t1_ram_addr", 64'(ram_addr), 64'd0);
    check("t1_level", 64'(level), 64'd1);
    to_pos();
    to_neg();
    check("t2_out_valid", 64'(out_valid), 64'd0);
    check("t2_level", 64'(level), 64'd1);
    to_pos();
    to_neg();
    check("t3_out_valid", 64'(out_valid), 64'd1);
    check("t3_out_data", 64'(out_data), 64'hA5A5_0001);
    to_pos();
    to_neg();
    check("t4_out_valid", 64'(out_valid), 64'd0);
    check("t4_level", 64'(level), 64'd0);
    to_pos();

    // ---------------- reset with a read in flight ----------------
    // Pointers are now wr=1, rd=1.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hBEEF_0001;
    to_neg();
    check("mr_w_addr", 64'(ram_addr), 64'd1);
    to_pos();
    in_data = 32'hBEEF_0002;
    to_neg();
    check("mr_r_in_ready", 64'(in_ready), 64'd0);
    to_pos();
    in_valid = 1'b0;
    check("mr_pre_level", 64'(level), 64'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mr_out_valid", 64'(out_valid), 64'd0);
    check("mr_level", 64'(level), 64'd0);
    check("mr_in_ready", 64'(in_ready), 64'd0);
    to_pos();
    rst_n = 1'b1;
    to_neg();
    check("mr_post_out_valid", 64'(out_valid), 64'd0);
    check("mr_post_level", 64'(level), 64'd0);
    to_pos();
    in_valid  = 1'b1;
    in_data   = 32'h1234_5678;
    out_ready = 1'b1;
    to_neg();
    check("mr_wr_addr", 64'(ram_addr), 64'd0);
    to_pos();
    in_valid = 1'b0;
    to_pos();
    to_pos();
    to_neg();
    check("mr_rd_valid", 64'(out_valid), 64'd1);
    check("mr_rd_data", 64'(out_data), 64'h1234_5678);
    to_pos();

    // ---------------- read priority over write ----------------
    // Pointers are now wr=1, rd=1, FIFO empty.
    start    = n_pop;
    in_valid = 1'b1;
    in_data  = 32'hC0DE_0001;
    to_neg();
    check("pr_t0_we", 64'(ram_we), 64'd1);
    check("pr_t0_addr", 64'(ram_addr), 64'd1);
    to_pos();
    in_data = 32'hC0DE_0002;
    to_neg();
    check("pr_t1_in_ready", 64'(in_ready), 64'd0);
    check("pr_t1_we", 64'(ram_we), 64'd0);
    check("pr_t1_addr", 64'(ram_addr), 64'd1);
    to_pos();
    to_neg();
    check("pr_t2_in_ready", 64'(in_ready), 64'd1);
    check("pr_t2_we", 64'(ram_we), 64'd1);
    check("pr_t2_addr", 64'(ram_addr), 64'd2);
    to_pos();
    in_valid = 1'b0;
    target   = start + 2;
    for (int i = 0; i < 20 && n_pop < target; i++) to_pos();
    check("pr_pops", 64'(n_pop - start), 64'd2);

    // ---------------- random backpressure stream ----------------
    start  = n_pop;
    n_sent = 0;
    for (int i = 0; i < 3000 && (n_pop - start) < 300; i++) begin
      in_valid  = (n_sent < 300);
      in_data   = 32'h1000_0000 + 32'(n_sent);
      out_ready = 1'($urandom_range(1, 0));
      to_neg();
      if (in_valid && in_ready) n_sent++;
      to_pos();
    end
    in_valid = 1'b0;
    check("st_sent", 64'(n_sent), 64'd300);
    check("st_pops", 64'(n_pop - start), 64'd300);
    check("st_level", 64'(level), 64'd0);

    // ---------------- fill to full, then drain ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    n_acc     = 0;
    for (int i = 0; i < 140; i++) begin
      in_data = 32'(n_acc);
      to_neg();
      if (in_ready) n_acc++;
      to_pos();
    end
    check("full_accepted", 64'(n_acc), 64'd129);
    check("full_level", 64'(level), 64'd129);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_out_data", 64'(out_data), 64'd0);
    repeat (5) to_pos();
    check("full_level_hold", 64'(level), 64'd129);
    check("full_in_ready_hold", 64'(in_ready), 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    start     = n_pop;
    for (int i = 0; i < 600 && (n_pop - start) < 129; i++) to_pos();
    check("drain_pops", 64'(n_pop - start), 64'd129);
    repeat (3) to_pos();
    check("drain_level", 64'(level), 64'd0);
    check("drain_out_valid", 64'(out_valid), 64'd0);
    check("drain_last", 64'(out_data), 64'd128);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
